// File: rtl/acc_requant.sv
// acc_requant: requantizes a stream of signed 32-bit MAC accumulators to int8
// and packs four results per 32-bit output word.
//
// Each accepted element is biased, rounded (round half up) by a right shift,
// saturated to [-128,127] and written into the next byte lane of a pack
// register. A word is emitted when lane 3 is written or when acc_last is
// accepted (partial flush, low lanes only, unfilled bytes zero).
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   shift, bias       quasi-static requant controls
//   acc_valid/ready   accumulator input handshake; acc_data, acc_last payload
//   out_valid/ready   packed word output handshake
//   out_data          lane i in bits [8i+7:8i]
//   out_keep          per-byte valid mask
//   out_last          word holds the acc_last element
//   sat_count         number of saturated elements, sticky at all-ones
//
// Optional feature macro: ACC_REQUANT_RELU_EN -- when defined, negative
// results are forced to zero after saturation (not counted as saturation).

module acc_requant #(
  parameter int LANES     = 4,
  parameter int SAT_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            shift,
  input  logic signed [31:0]    bias,
  input  logic                  acc_valid,
  output logic                  acc_ready,
  input  logic signed [31:0]    acc_data,
  input  logic                  acc_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*LANES-1:0]    out_data,
  output logic [LANES-1:0]      out_keep,
  output logic                  out_last,
  output logic [SAT_CNT_W-1:0]  sat_count
);

  localparam int LANE_W = $clog2(LANES);

  // Round half up: add 2^(sh-1) before the arithmetic shift. 34 bits holds
  // the 33-bit sum plus the rounding constant without wrapping.
  function automatic logic signed [33:0] round_shift(input logic signed [32:0] sum,
                                                      input logic [4:0]         sh);
    logic signed [33:0] ext;
    logic signed [33:0] half;
    ext  = {sum[32], sum};
    half = (sh == 5'd0) ? 34'sd0 : (34'sd1 <<< (sh - 5'd1));
    return (ext + half) >>> sh;
  endfunction

  function automatic logic signed [7:0] sat8(input logic signed [33:0] v);
    if (v > 34'sd127)       return 8'h7F;
    else if (v < -34'sd128) return 8'h80;
    else                    return v[7:0];
  endfunction

  function automatic logic is_sat(input logic signed [33:0] v);
    return (v > 34'sd127) || (v < -34'sd128);
  endfunction

  logic [LANE_W-1:0]     r_lane;
  logic [8*LANES-1:0]    r_pack;
  logic                  r_out_valid;
  logic [8*LANES-1:0]    r_out_data;
  logic [LANES-1:0]      r_out_keep;
  logic                  r_out_last;
  logic [SAT_CNT_W-1:0]  r_sat_count;

  logic                  w_accept;
  logic                  w_complete;
  logic signed [32:0]    w_sum;
  logic signed [33:0]    w_shifted;
  logic signed [7:0]     w_sat8;
  logic                  w_sat;
  logic signed [7:0]     w_res;
  logic [8*LANES-1:0]    w_word;
  logic [LANES-1:0]      w_keep;

  // A new element may enter whenever the output register is free or draining
  // this cycle, so a completion can reload it back-to-back.
  assign acc_ready  = !r_out_valid || out_ready;
  assign w_accept   = acc_valid && acc_ready;
  assign w_complete = w_accept && ((r_lane == LANE_W'(LANES - 1)) || acc_last);

  // ---- stage 0: bias, round, saturate (combinational on the accepted element)
  assign w_sum     = {acc_data[31], acc_data} + {bias[31], bias};
  assign w_shifted = round_shift(w_sum, shift);
  assign w_sat8    = sat8(w_shifted);
  assign w_sat     = is_sat(w_shifted);

`ifdef ACC_REQUANT_RELU_EN
  assign w_res = w_sat8[7] ? 8'sh00 : w_sat8;
`else
  assign w_res = w_sat8;
`endif

  // Merge the new byte into the pack image; keep covers lanes 0..r_lane.
  always_comb begin
    w_word = r_pack;
    w_keep = '0;
    for (int i = 0; i < LANES; i++) begin
      if (LANE_W'(i) == r_lane) w_word[8*i +: 8] = w_res;
      if (LANE_W'(i) <= r_lane) w_keep[i] = 1'b1;
    end
  end

  // ---- stage 1: pack register, lane counter, output register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lane      <= '0;
      r_pack      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_last  <= 1'b0;
      r_sat_count <= '0;
    end else begin
      if (w_accept) begin
        if (w_complete) begin
          // Pack register returns to zero so unfilled bytes of the next
          // partial word read as 0x00.
          r_pack     <= '0;
          r_lane     <= '0;
          r_out_data <= w_word;
          r_out_keep <= w_keep;
          r_out_last <= acc_last;
        end else begin
          r_pack <= w_word;
          r_lane <= r_lane + LANE_W'(1);
        end
        if (w_sat && (r_sat_count != '1))
          r_sat_count <= r_sat_count + SAT_CNT_W'(1);
      end

      if (w_complete)
        r_out_valid <= 1'b1;
      else if (out_ready)
        r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_keep  = r_out_keep;
  assign out_last  = r_out_last;
  assign sat_count = r_sat_count;

endmodule

// File: tb/tb_acc_requant.sv
// Testbench for acc_requant: directed vectors with hand-computed expected
// words pushed to a scoreboard queue; an independent monitor pops and
// compares on every output handshake and checks output stability on stalls.

module tb_acc_requant;

  logic               clk;
  logic               rst;
  logic [4:0]         shift;
  logic signed [31:0] bias;
  logic               acc_valid;
  logic               acc_ready;
  logic signed [31:0] acc_data;
  logic               acc_last;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_data;
  logic [3:0]         out_keep;
  logic               out_last;
  logic [15:0]        sat_count;

  acc_requant #(.LANES(4), .SAT_CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .shift     (shift),
    .bias      (bias),
    .acc_valid (acc_valid),
    .acc_ready (acc_ready),
    .acc_data  (acc_data),
    .acc_last  (acc_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last),
    .sat_count (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [3:0] k, input logic l);
    exp_t e;
    e.d = d; e.k = k; e.l = l;
    q.push_back(e);
  endtask

  // Present one element and return just after the edge that accepts it.
  task automatic send(input logic signed [31:0] d, input logic l);
    int t;
    t = 0;
    acc_valid = 1'b1;
    acc_data  = d;
    acc_last  = l;
    while (1) begin
      @(negedge clk);
      if (acc_ready) break;
      t++;
      if (t > 200) begin
        n_checks++;
        $display("FAIL send_timeout: acc_ready stuck 0 for element %0d", d);
        break;
      end
    end
    @(posedge clk); #1;
    acc_valid = 1'b0;
    acc_last  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(posedge clk); t++;
    end
    @(posedge clk); #1;
    chk("drain_queue_empty", q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Monitor: scoreboard pop on handshake, stability check while stalled.
  logic        hold_v = 1'b0;
  logic [36:0] hold_w;
  always @(negedge clk) begin
    exp_t e;
    if (hold_v && !rst) begin
      chk("stall_stable", {out_data, out_keep, out_last}, hold_w);
    end
    hold_v = out_valid && !out_ready && !rst;
    hold_w = {out_data, out_keep, out_last};
    if (out_valid && out_ready && !rst) begin
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_word: got 0x%08h with empty scoreboard", out_data);
      end else begin
        e = q.pop_front();
        chk("word_data", out_data, e.d);
        chk("word_keep", {28'd0, out_keep}, {28'd0, e.k});
        chk("word_last", {31'd0, out_last}, {31'd0, e.l});
      end
    end
  end

  initial begin
    rst = 1'b1; shift = 5'd0; bias = 32'sd0; acc_valid = 1'b0;
    acc_data = 32'sd0; acc_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, first cycle after reset release
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  out_data, 32'd0);
    chk("rst_out_keep",  {28'd0, out_keep}, 32'd0);
    chk("rst_out_last",  {31'd0, out_last}, 32'd0);
    chk("rst_sat_count", {16'd0, sat_count}, 32'd0);
    chk("rst_acc_ready", {31'd0, acc_ready}, 32'd1);

    // Plain pass-through packing, latency one edge after the 4th accept
    expect_word(32'h04030201, 4'hF, 1'b0);
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    chk("latency_valid", {31'd0, out_valid}, 32'd1);
    drain();

    // Rounding and saturation at shift=3
    shift = 5'd3;
`ifdef ACC_REQUANT_RELU_EN
    expect_word(32'h007F007D, 4'hF, 1'b0);
`else
    expect_word(32'h807F837D, 4'hF, 1'b0);
`endif
    send(1000, 0); send(-1000, 0); send(2000, 0); send(-2000, 0);
    drain();
    chk("sat_count_2", {16'd0, sat_count}, 32'd2);

    // Partial flush, then lane-0 restart with last on lane 3, then last on lane 0
    shift = 5'd0;
    expect_word(32'h00000201, 4'h3, 1'b1);
    expect_word(32'h08070605, 4'hF, 1'b1);
    expect_word(32'h00000009, 4'h1, 1'b1);
    send(1, 0); send(2, 1);
    send(5, 0); send(6, 0); send(7, 0); send(8, 1);
    send(9, 1);
    drain();

    // Negative bias with rounding toward +inf at the half
    bias = -32'sd16; shift = 5'd4;
`ifdef ACC_REQUANT_RELU_EN
    expect_word(32'h00000001, 4'h3, 1'b1);
`else
    expect_word(32'h0000FF01, 4'h3, 1'b1);
`endif
    send(24, 0); send(7, 1);
    drain();
    chk("sat_count_still_2", {16'd0, sat_count}, 32'd2);

    // Backpressure: 12 elements offered with out_ready low, then released
    bias = 32'sd0; shift = 5'd0;
    out_ready = 1'b0;
    expect_word(32'h04030201, 4'hF, 1'b0);
    expect_word(32'h08070605, 4'hF, 1'b0);
    expect_word(32'h0C0B0A09, 4'hF, 1'b0);
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    fork
      begin
        for (int v = 5; v <= 12; v++) send(v, 0);
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        chk("bp_acc_ready_low", {31'd0, acc_ready}, 32'd0);
        chk("bp_out_data_held", out_data, 32'h04030201);
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-word discards partial results and clears sat_count
    shift = 5'd5;
    send(32'sd100000, 0); send(-32'sd100000, 0);
    chk("pre_rst_sat", {16'd0, sat_count}, 32'd4);
    do_reset();
    shift = 5'd0;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_sat_count", {16'd0, sat_count}, 32'd0);
    expect_word(32'h24232221, 4'hF, 1'b0);
    send(32'h21, 0); send(32'h22, 0); send(32'h23, 0); send(32'h24, 0);
    drain();
    chk("post_rst_sat_count", {16'd0, sat_count}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
